// File: rtl/spaceinv_pkg.sv
// Shared types and default tuning constants for the game-flow controller.
package spaceinv_pkg;

    typedef enum logic [2:0] {
        ATTRACT   = 3'd0,
        PLAY      = 3'd1,
        PAUSE     = 3'd2,
        DYING     = 3'd3,
        LEVEL_UP  = 3'd4,
        GAME_OVER = 3'd5
    } gstate_t;

    localparam int unsigned DEF_NUM_LIVES    = 3;
    localparam int unsigned DEF_NUM_LEVELS   = 4;
    localparam int unsigned DEF_DEATH_FRAMES = 60;
    localparam int unsigned DEF_LEVEL_FRAMES = 90;
    localparam int unsigned DEF_OVER_FRAMES  = 180;
    localparam int unsigned DEF_PAUSE_EN     = 1;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Player/game-event inputs and game-status outputs of the game-flow controller.
interface game_state_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic       play;
    logic       hit;
    logic       wave_clear;
    logic       landed;
    logic [2:0] state;
    logic [3:0] lives;
    logic [3:0] level;
    logic       run_en;
    logic       game_over;

    modport master (
        output frame_tick, start, play, hit, wave_clear, landed,
        input  state, lives, level, run_en, game_over
    );

    modport slave (
        input  frame_tick, start, play, hit, wave_clear, landed,
        output state, lives, level, run_en, game_over
    );
endinterface

// File: rtl/game_state_ctrl_frame_timer.sv
// Frame-tick counter for timed states; clear is held high for the state-entry cycle.
module frame_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic [WIDTH-1:0] load,
    output logic             expired
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_eff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count < load)) begin
            count <= count + WIDTH'(1);
        end
    end

    // Entry cycle reads as zero so a zero load expires immediately.
    assign count_eff = clear ? '0 : count;
    assign expired   = (count_eff >= load);

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level game-flow state machine: attract, play, pause, death, level-up, game over.
module game_state_ctrl
    import spaceinv_pkg::*;
#(
    parameter int unsigned NUM_LIVES    = DEF_NUM_LIVES,
    parameter int unsigned NUM_LEVELS   = DEF_NUM_LEVELS,
    parameter int unsigned DEATH_FRAMES = DEF_DEATH_FRAMES,
    parameter int unsigned LEVEL_FRAMES = DEF_LEVEL_FRAMES,
    parameter int unsigned OVER_FRAMES  = DEF_OVER_FRAMES,
    parameter int unsigned PAUSE_EN     = DEF_PAUSE_EN
) (
    input  logic             clk,
    input  logic             reset,
    game_state_ctrl_if.slave bus
);

    localparam int unsigned CW = $clog2(max3(DEATH_FRAMES, LEVEL_FRAMES, OVER_FRAMES)) + 1;

    gstate_t       state_q, nxt;
    logic [3:0]    lives_q, lives_nxt;
    logic [3:0]    level_q, level_nxt;
    logic          run_en_q, game_over_q, entry_q, start_prev;
    logic          start_edge, expired;
    logic [CW-1:0] load;

    assign start_edge = bus.start && !start_prev;

    always_comb begin
        load = '0;
        case (state_q)
            DYING:     load = CW'(DEATH_FRAMES);
            LEVEL_UP:  load = CW'(LEVEL_FRAMES);
            GAME_OVER: load = CW'(OVER_FRAMES);
            default:   load = '0;
        endcase
    end

    frame_timer #(.WIDTH(CW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (entry_q),
        .tick    (bus.frame_tick),
        .load    (load),
        .expired (expired)
    );

    always_comb begin
        nxt       = state_q;
        lives_nxt = lives_q;
        level_nxt = level_q;
        case (state_q)
            ATTRACT: begin
                if (start_edge && bus.play) begin
                    nxt       = PLAY;
                    lives_nxt = 4'(NUM_LIVES);
                    level_nxt = '0;
                end
            end
            PLAY: begin
                if (bus.landed) begin
                    nxt       = GAME_OVER;
                    lives_nxt = '0;
                end else if (bus.hit) begin
                    lives_nxt = lives_q - 4'd1;
                    nxt       = (lives_q == 4'd1) ? GAME_OVER : DYING;
                end else if (bus.wave_clear) begin
                    level_nxt = (level_q == 4'(NUM_LEVELS - 1)) ? '0 : level_q + 4'd1;
                    nxt       = LEVEL_UP;
                end else if (!bus.play && (PAUSE_EN != 0)) begin
                    nxt = PAUSE;
                end
            end
            PAUSE:          if (bus.play) nxt = PLAY;
            DYING, LEVEL_UP: if (expired) nxt = PLAY;
            GAME_OVER:      if (expired || start_edge) nxt = ATTRACT;
            default:        nxt = ATTRACT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ATTRACT;
            lives_q     <= '0;
            level_q     <= '0;
            run_en_q    <= 1'b0;
            game_over_q <= 1'b0;
            entry_q     <= 1'b0;
            start_prev  <= 1'b1;
        end else begin
            state_q     <= nxt;
            lives_q     <= lives_nxt;
            level_q     <= level_nxt;
            run_en_q    <= (nxt == PLAY);
            game_over_q <= (nxt == GAME_OVER);
            entry_q     <= (nxt != state_q);
            start_prev  <= bus.start;
        end
    end

    assign bus.state     = state_q;
    assign bus.lives     = lives_q;
    assign bus.level     = level_q;
    assign bus.run_en    = run_en_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: one task per scenario, inline checks on the falling edge.
module tb_game_state_ctrl;
    import spaceinv_pkg::*;

    localparam logic [2:0] S_ATTRACT = ATTRACT;
    localparam logic [2:0] S_PLAY    = PLAY;
    localparam logic [2:0] S_PAUSE   = PAUSE;
    localparam logic [2:0] S_DYING   = DYING;
    localparam logic [2:0] S_LVLUP   = LEVEL_UP;
    localparam logic [2:0] S_OVER    = GAME_OVER;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;

    game_state_ctrl_if bus_a ();
    game_state_ctrl_if bus_b ();

    game_state_ctrl #(
        .NUM_LIVES(3), .NUM_LEVELS(4), .DEATH_FRAMES(2),
        .LEVEL_FRAMES(3), .OVER_FRAMES(5), .PAUSE_EN(1)
    ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    game_state_ctrl #(
        .NUM_LIVES(3), .NUM_LEVELS(4), .DEATH_FRAMES(2),
        .LEVEL_FRAMES(0), .OVER_FRAMES(5), .PAUSE_EN(0)
    ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    // One counted frame tick: pulse for a cycle, then one idle cycle.
    task automatic tick_a(input int n);
        for (int i = 0; i < n; i++) begin
            bus_a.frame_tick = 1'b1; cyc();
            bus_a.frame_tick = 1'b0; cyc();
        end
    endtask

    task automatic start_game_a();
        bus_a.start = 1'b1; cyc();
        bus_a.start = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        checks++; if (bus_a.state !== S_ATTRACT) $display("FAIL rst_state got %0d want %0d", bus_a.state, S_ATTRACT); else passed++;
        checks++; if (bus_a.lives !== 4'd0) $display("FAIL rst_lives got %0d want 0", bus_a.lives); else passed++;
        checks++; if (bus_a.level !== 4'd0) $display("FAIL rst_level got %0d want 0", bus_a.level); else passed++;
        checks++; if (bus_a.run_en !== 1'b0 || bus_a.game_over !== 1'b0) $display("FAIL rst_flags got %b%b want 00", bus_a.run_en, bus_a.game_over); else passed++;
        reset = 1'b1;
        repeat (10) cyc();
        checks++; if (bus_a.state !== S_ATTRACT) $display("FAIL held_start_state got %0d want %0d", bus_a.state, S_ATTRACT); else passed++;
        checks++; if (bus_a.run_en !== 1'b0) $display("FAIL held_start_run got %b want 0", bus_a.run_en); else passed++;
        bus_a.start = 1'b0; cyc();
    endtask

    task automatic test_hits();
        start_game_a();
        checks++; if (bus_a.state !== S_PLAY) $display("FAIL start_state got %0d want %0d", bus_a.state, S_PLAY); else passed++;
        checks++; if (bus_a.lives !== 4'd3 || bus_a.level !== 4'd0) $display("FAIL start_lives_level got %0d/%0d want 3/0", bus_a.lives, bus_a.level); else passed++;
        checks++; if (bus_a.run_en !== 1'b1) $display("FAIL start_run got %b want 1", bus_a.run_en); else passed++;
        bus_a.hit = 1'b1; cyc(); bus_a.hit = 1'b0;
        checks++; if (bus_a.state !== S_DYING || bus_a.lives !== 4'd2) $display("FAIL hit1 got st%0d l%0d want st%0d l2", bus_a.state, bus_a.lives, S_DYING); else passed++;
        checks++; if (bus_a.run_en !== 1'b0) $display("FAIL hit1_run got %b want 0", bus_a.run_en); else passed++;
        cyc(); tick_a(1);
        checks++; if (bus_a.state !== S_DYING) $display("FAIL dying_one_tick got %0d want %0d", bus_a.state, S_DYING); else passed++;
        tick_a(1);
        checks++; if (bus_a.state !== S_PLAY || bus_a.lives !== 4'd2) $display("FAIL dying_exit got st%0d l%0d want st%0d l2", bus_a.state, bus_a.lives, S_PLAY); else passed++;
        bus_a.hit = 1'b1; cyc(); bus_a.hit = 1'b0;
        checks++; if (bus_a.state !== S_DYING || bus_a.lives !== 4'd1) $display("FAIL hit2 got st%0d l%0d want st%0d l1", bus_a.state, bus_a.lives, S_DYING); else passed++;
        cyc(); tick_a(2);
        checks++; if (bus_a.state !== S_PLAY) $display("FAIL dying2_exit got %0d want %0d", bus_a.state, S_PLAY); else passed++;
        bus_a.hit = 1'b1; cyc(); bus_a.hit = 1'b0;
        checks++; if (bus_a.state !== S_OVER || bus_a.lives !== 4'd0) $display("FAIL hit3 got st%0d l%0d want st%0d l0", bus_a.state, bus_a.lives, S_OVER); else passed++;
        checks++; if (bus_a.game_over !== 1'b1 || bus_a.run_en !== 1'b0) $display("FAIL hit3_flags got go%b run%b want go1 run0", bus_a.game_over, bus_a.run_en); else passed++;
    endtask

    task automatic test_over_timeout();
        cyc(); tick_a(4);
        checks++; if (bus_a.state !== S_OVER || bus_a.lives !== 4'd0) $display("FAIL over_4ticks got st%0d l%0d want st%0d l0", bus_a.state, bus_a.lives, S_OVER); else passed++;
        tick_a(1);
        checks++; if (bus_a.state !== S_ATTRACT) $display("FAIL over_timeout got %0d want %0d", bus_a.state, S_ATTRACT); else passed++;
        checks++; if (bus_a.game_over !== 1'b0) $display("FAIL over_timeout_flag got %b want 0", bus_a.game_over); else passed++;
    endtask

    task automatic test_level_wrap();
        start_game_a();
        checks++; if (bus_a.state !== S_PLAY || bus_a.lives !== 4'd3) $display("FAIL restart got st%0d l%0d want st%0d l3", bus_a.state, bus_a.lives, S_PLAY); else passed++;
        for (int i = 1; i <= 3; i++) begin
            bus_a.wave_clear = 1'b1; cyc(); bus_a.wave_clear = 1'b0;
            checks++; if (bus_a.state !== S_LVLUP || bus_a.level !== 4'(i)) $display("FAIL wave%0d got st%0d lv%0d want st%0d lv%0d", i, bus_a.state, bus_a.level, S_LVLUP, i); else passed++;
            cyc(); tick_a(3);
            checks++; if (bus_a.state !== S_PLAY) $display("FAIL lvlup%0d_exit got %0d want %0d", i, bus_a.state, S_PLAY); else passed++;
        end
        bus_a.wave_clear = 1'b1; cyc(); bus_a.wave_clear = 1'b0;
        checks++; if (bus_a.state !== S_LVLUP || bus_a.level !== 4'd0) $display("FAIL wrap got st%0d lv%0d want st%0d lv0", bus_a.state, bus_a.level, S_LVLUP); else passed++;
        bus_a.frame_tick = 1'b1; cyc(); bus_a.frame_tick = 1'b0; cyc();
        tick_a(2);
        checks++; if (bus_a.state !== S_LVLUP) $display("FAIL entry_tick_ignored got %0d want %0d", bus_a.state, S_LVLUP); else passed++;
        tick_a(1);
        checks++; if (bus_a.state !== S_PLAY || bus_a.level !== 4'd0 || bus_a.run_en !== 1'b1) $display("FAIL wrap_exit got st%0d lv%0d run%b want st%0d lv0 run1", bus_a.state, bus_a.level, bus_a.run_en, S_PLAY); else passed++;
    endtask

    task automatic test_priority();
        bus_a.hit = 1'b1; bus_a.wave_clear = 1'b1; cyc(); bus_a.hit = 1'b0; bus_a.wave_clear = 1'b0;
        checks++; if (bus_a.state !== S_DYING || bus_a.lives !== 4'd2 || bus_a.level !== 4'd0) $display("FAIL hit_wave got st%0d l%0d lv%0d want st%0d l2 lv0", bus_a.state, bus_a.lives, bus_a.level, S_DYING); else passed++;
        cyc(); tick_a(2);
        bus_a.hit = 1'b1; bus_a.landed = 1'b1; cyc(); bus_a.hit = 1'b0; bus_a.landed = 1'b0;
        checks++; if (bus_a.state !== S_OVER || bus_a.lives !== 4'd0) $display("FAIL hit_landed got st%0d l%0d want st%0d l0", bus_a.state, bus_a.lives, S_OVER); else passed++;
        cyc(); tick_a(2);
        bus_a.start = 1'b1; cyc();
        checks++; if (bus_a.state !== S_ATTRACT) $display("FAIL over_start_edge got %0d want %0d", bus_a.state, S_ATTRACT); else passed++;
        bus_a.start = 1'b0; cyc();
    endtask

    task automatic test_pause();
        start_game_a();
        bus_a.play = 1'b0; cyc();
        checks++; if (bus_a.state !== S_PAUSE || bus_a.run_en !== 1'b0) $display("FAIL pause got st%0d run%b want st%0d run0", bus_a.state, bus_a.run_en, S_PAUSE); else passed++;
        bus_a.hit = 1'b1; cyc(); bus_a.hit = 1'b0;
        checks++; if (bus_a.state !== S_PAUSE || bus_a.lives !== 4'd3) $display("FAIL pause_hit got st%0d l%0d want st%0d l3", bus_a.state, bus_a.lives, S_PAUSE); else passed++;
        bus_a.play = 1'b1; cyc();
        checks++; if (bus_a.state !== S_PLAY || bus_a.run_en !== 1'b1) $display("FAIL resume got st%0d run%b want st%0d run1", bus_a.state, bus_a.run_en, S_PLAY); else passed++;
        bus_b.start = 1'b1; cyc(); bus_b.start = 1'b0;
        bus_b.play = 1'b0; cyc(); cyc();
        checks++; if (bus_b.state !== S_PLAY || bus_b.run_en !== 1'b1) $display("FAIL nopause got st%0d run%b want st%0d run1", bus_b.state, bus_b.run_en, S_PLAY); else passed++;
        bus_b.wave_clear = 1'b1; cyc(); bus_b.wave_clear = 1'b0;
        checks++; if (bus_b.state !== S_LVLUP || bus_b.level !== 4'd1) $display("FAIL zero_frames_enter got st%0d lv%0d want st%0d lv1", bus_b.state, bus_b.level, S_LVLUP); else passed++;
        cyc();
        checks++; if (bus_b.state !== S_PLAY) $display("FAIL zero_frames_exit got %0d want %0d", bus_b.state, S_PLAY); else passed++;
    endtask

    task automatic test_reset_mid_game();
        bus_a.wave_clear = 1'b1; cyc(); bus_a.wave_clear = 1'b0;
        cyc(); tick_a(3);
        bus_a.hit = 1'b1; cyc(); bus_a.hit = 1'b0;
        checks++; if (bus_a.state !== S_DYING || bus_a.level !== 4'd1) $display("FAIL pre_reset got st%0d lv%0d want st%0d lv1", bus_a.state, bus_a.level, S_DYING); else passed++;
        #2 reset = 1'b0;
        #1;
        checks++; if (bus_a.state !== S_ATTRACT || bus_a.lives !== 4'd0 || bus_a.level !== 4'd0) $display("FAIL async_reset got st%0d l%0d lv%0d want st%0d l0 lv0", bus_a.state, bus_a.lives, bus_a.level, S_ATTRACT); else passed++;
        checks++; if (bus_b.state !== S_ATTRACT || bus_a.run_en !== 1'b0) $display("FAIL async_reset_b got st%0d run%b want st%0d run0", bus_b.state, bus_a.run_en, S_ATTRACT); else passed++;
        cyc(); reset = 1'b1; cyc(); cyc();
        checks++; if (bus_a.state !== S_ATTRACT) $display("FAIL post_reset got %0d want %0d", bus_a.state, S_ATTRACT); else passed++;
    endtask

    initial begin
        reset = 1'b0;
        bus_a.frame_tick = 1'b0; bus_a.start = 1'b1; bus_a.play = 1'b1;
        bus_a.hit = 1'b0; bus_a.wave_clear = 1'b0; bus_a.landed = 1'b0;
        bus_b.frame_tick = 1'b0; bus_b.start = 1'b0; bus_b.play = 1'b1;
        bus_b.hit = 1'b0; bus_b.wave_clear = 1'b0; bus_b.landed = 1'b0;
        test_reset();
        test_hits();
        test_over_timeout();
        test_level_wrap();
        test_priority();
        test_pause();
        test_reset_mid_game();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
